// File: rtl/rdmap_ct_rd.sv
// rdmap_ct_rd: corner-turn reader that walks a chirp-major BRAM column-wise
// and emits one sop/eop-framed Doppler vector per range bin.
module rdmap_ct_rd #(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 2,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [15:0]       sample_num_i,
    input  logic [15:0]       chirp_num_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [15:0]       rd_data_i,
    output logic [15:0]       data_out_o,
    output logic              data_valid_o,
    output logic              data_sop_o,
    output logic              data_eop_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;
    state_t                 state_q;
    logic [15:0]            samp_q, chirp_q, s_q, c_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             cnt_q;
    logic                   cfg_err_q;
    logic [RD_LAT-1:0][2:0] tag_q;
    logic                   vld_q, sop_q, eop_q;
    logic [15:0]            dout_q;
    logic                   legal, bad, last_c, last_s;
    logic [63:0]            span;
    always_comb begin
        legal  = chirp_q == 16'd32 || chirp_q == 16'd64 || chirp_q == 16'd128;
        // chirp_num is a power of two here, so the frame size is a shift
        span   = {48'd0, samp_q} << (chirp_q == 16'd32 ? 5 : chirp_q == 16'd64 ? 6 : 7);
        bad    = !legal || samp_q == 16'd0 || span > (64'd1 << ADDR_W);
        last_c = c_q == chirp_q - 16'd1;
        last_s = s_q == samp_q - 16'd1;
    end
    assign rd_en_o      = state_q == S_RUN;
    assign rd_addr_o    = addr_q;
    assign busy_o       = state_q != S_IDLE && state_q != S_DONE;
    assign done_o       = state_q == S_DONE;
    assign cfg_err_o    = cfg_err_q;
    assign data_out_o   = dout_q;
    assign data_valid_o = vld_q;
    assign data_sop_o   = sop_q;
    assign data_eop_o   = eop_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            samp_q    <= '0;
            chirp_q   <= '0;
            s_q       <= '0;
            c_q       <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q   <= S_CHECK;
                    samp_q    <= sample_num_i;
                    chirp_q   <= chirp_num_i;
                    cfg_err_q <= 1'b0;
                end
                S_CHECK: if (bad) begin
                    cfg_err_q <= 1'b1;
                    state_q   <= S_DONE;
                end else begin
                    state_q <= S_RUN;
                    s_q     <= '0;
                    c_q     <= '0;
                    addr_q  <= '0;
                end
                // address advances by one row per chirp: c*sample_num+s without a multiplier
                S_RUN: if (!last_c) begin
                    c_q    <= c_q + 16'd1;
                    addr_q <= addr_q + ADDR_W'(samp_q);
                end else if (last_s) begin
                    state_q <= S_DRAIN;
                    cnt_q   <= '0;
                end else begin
                    state_q <= S_GAP;
                    s_q     <= s_q + 16'd1;
                    c_q     <= '0;
                    addr_q  <= ADDR_W'(s_q + 16'd1);
                    cnt_q   <= '0;
                end
                S_GAP: if (cnt_q == 8'(GAP - 1)) state_q <= S_RUN;
                       else cnt_q <= cnt_q + 8'd1;
                // RD_LAT+1 cycles so done follows the final registered eop
                S_DRAIN: if (cnt_q == 8'(RD_LAT)) state_q <= S_DONE;
                         else cnt_q <= cnt_q + 8'd1;
                default: state_q <= S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q  <= '0;
            vld_q  <= 1'b0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            tag_q[0] <= {rd_en_o, rd_en_o && c_q == 16'd0, rd_en_o && last_c};
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            {vld_q, sop_q, eop_q} <= tag_q[RD_LAT-1];
            if (tag_q[RD_LAT-1][2]) dout_q <= rd_data_i;
        end
    end
endmodule

// File: tb/tb_rdmap_ct_rd.sv
// tb_rdmap_ct_rd: scoreboard bench for the corner-turn reader with a
// two-cycle BRAM model holding mem[a] = a.
module tb_rdmap_ct_rd;
    localparam int ADDR_W = 17;
    localparam int RD_LAT = 2;
    localparam int GAP    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       sample_num = '0;
    logic [15:0]       chirp_num = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data = '0;
    logic [15:0]       p1 = '0;
    logic [15:0]       data_out;
    logic              data_valid, data_sop, data_eop, busy, done, cfg_err;

    rdmap_ct_rd #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start_i(start), .sample_num_i(sample_num),
        .chirp_num_i(chirp_num), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
        .rd_data_i(rd_data), .data_out_o(data_out), .data_valid_o(data_valid),
        .data_sop_o(data_sop), .data_eop_o(data_eop), .busy_o(busy),
        .done_o(done), .cfg_err_o(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        p1      <= rd_en ? rd_addr[15:0] : 16'hDEAD;
        rd_data <= p1;
    end

    typedef struct packed {logic [15:0] d; logic sop; logic eop;} exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0;
    int first_rden, first_vld, n_rden, last_addr, eop_cyc, last_vld;
    bit have_eop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                n_rden++;
                last_addr = int'(rd_addr);
                if (first_rden < 0) first_rden = cyc;
            end
            if (data_valid) begin
                exp_t e;
                if (first_vld < 0) begin
                    first_vld = cyc;
                    check("latency", 64'(cyc - first_rden), 64'(RD_LAT + 1));
                end
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("data", data_out, e.d);
                    check("sop", data_sop, e.sop);
                    check("eop", data_eop, e.eop);
                end
                if (data_sop && have_eop) check("gap", 64'(cyc - eop_cyc - 1), 64'(GAP));
                if (!data_sop) check("contig", 64'(cyc - last_vld), 1);
                last_vld = cyc;
                if (data_eop) begin
                    eop_cyc  = cyc;
                    have_eop = 1'b1;
                end
            end else check("idle_tags", {data_sop, data_eop}, 0);
        end
    end

    task automatic clear_mon();
        first_rden = -1; first_vld = -1; n_rden = 0; last_addr = -1;
        eop_cyc = -10; last_vld = -10; have_eop = 1'b0;
    endtask

    task automatic push_frame(input int s_n, input int c_n);
        for (int s = 0; s < s_n; s++)
            for (int c = 0; c < c_n; c++) begin
                exp_t e;
                e.d   = 16'(c * s_n + s);
                e.sop = (c == 0);
                e.eop = (c == c_n - 1);
                sb.push_back(e);
            end
    endtask

    task automatic run_frame(input int s_n, input int c_n, input bit bad, input bit restart);
        int t0;
        bit got;
        clear_mon();
        if (!bad) push_frame(s_n, c_n);
        @(posedge clk); #1;
        start = 1'b1; sample_num = 16'(s_n); chirp_num = 16'(c_n); t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_on", busy, 1);
        check("cfg_err_clr", cfg_err, 0);
        if (restart) begin
            repeat (20) @(posedge clk);
            #1 start = 1'b1; sample_num = 16'd7; chirp_num = 16'd32;
            @(posedge clk); #1 start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 100000 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        check("done_seen", got, 1);
        check("done_time", 64'(cyc - t0), bad ? 64'd2 : 64'(s_n * c_n + (s_n - 1) * GAP + RD_LAT + 3));
        check("cfg_err", cfg_err, bad);
        check("n_rden", 64'(n_rden), bad ? 64'd0 : 64'(s_n * c_n));
        check("sb_empty", 64'(sb.size()), 0);
        if (!bad) check("done_after_eop", 64'(cyc - eop_cyc), 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_off", busy, 0);
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_valid", data_valid, 0);
        check("rst_sop", data_sop, 0);
        check("rst_eop", data_eop, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);

        run_frame(4, 32, 1'b0, 1'b0);
        run_frame(4, 48, 1'b1, 1'b0);
        run_frame(2, 64, 1'b0, 1'b1);
        run_frame(0, 32, 1'b1, 1'b0);
        run_frame(1025, 128, 1'b1, 1'b0);

        clear_mon();
        push_frame(4, 32);
        @(posedge clk); #1;
        start = 1'b1; sample_num = 16'd4; chirp_num = 16'd32;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rd_en", rd_en, 0);
        check("abort_valid", data_valid, 0);
        check("abort_busy", busy, 0);
        sb.delete();
        run_frame(2, 64, 1'b0, 1'b0);

        run_frame(512, 128, 1'b0, 1'b0);
        check("last_addr", 64'(last_addr), 65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
